// File: rtl/dma_bus_arbiter_if.sv
// Memory-port sharing bundle between CPU, DMA engine and the dma_bus_arbiter.
// Optional viol_cnt signal exists only when DMA_VIOL_CNT_EN is defined.
interface dma_bus_arbiter_if;
    logic [15:0] pc;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_sel;
    logic        cpu_gnt;
    logic        dma_gnt;
    logic        dma_deny;
    logic        kill;
`ifdef DMA_VIOL_CNT_EN
    logic [7:0]  viol_cnt;
`endif

    // Arbiter side: samples requests, drives the memory port and grants.
    modport master (
        input  pc,
        input  cpu_req,
        input  cpu_addr,
        input  dma_req,
        input  dma_addr,
        output mem_en,
        output mem_addr,
        output mem_sel,
        output cpu_gnt,
        output dma_gnt,
        output dma_deny,
        output kill
`ifdef DMA_VIOL_CNT_EN
        , output viol_cnt
`endif
    );

    modport slave (
        output pc,
        output cpu_req,
        output cpu_addr,
        output dma_req,
        output dma_addr,
        input  mem_en,
        input  mem_addr,
        input  mem_sel,
        input  cpu_gnt,
        input  dma_gnt,
        input  dma_deny,
        input  kill
`ifdef DMA_VIOL_CNT_EN
        , input  viol_cnt
`endif
    );
endinterface

// File: rtl/dma_bus_arbiter.sv
// CPU/DMA memory-port arbiter with secure-memory isolation and kill request.
// Define DMA_VIOL_CNT_EN to add the saturating viol_cnt output.
module dma_bus_arbiter #(
    parameter logic [15:0] SMEM_BASE     = 16'hE000,
    parameter logic [15:0] SMEM_SIZE     = 16'h1000,
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int unsigned MAX_WAIT      = 4
) (
    input  logic              clk,
    input  logic              reset,
    dma_bus_arbiter_if.master bus
);

    localparam logic [16:0] SMEM_END       = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE};
    localparam logic [15:0] LAST_SMEM_ADDR = 16'(SMEM_END - 17'd2);
    localparam logic [3:0]  MAX_WAIT_C     = 4'(MAX_WAIT);

    typedef enum logic {S_RUN, S_KILL} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;

    logic        mem_en_d, mem_sel_d, cpu_gnt_d, dma_gnt_d, dma_deny_d;
    logic [15:0] mem_addr_d;

    logic        mem_en_p1, mem_sel_p1, cpu_gnt_p1, dma_gnt_p1, dma_deny_p1, kill_p1;
    logic [15:0] mem_addr_p1;

    logic        dma_in_smem, pc_in_smem, dma_viol;

    function automatic logic [3:0] sat_inc_wait(input logic [3:0] v);
        return (v >= MAX_WAIT_C) ? MAX_WAIT_C : v + 4'd1;
    endfunction

    function automatic logic [7:0] sat_inc_viol(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign dma_in_smem = (bus.dma_addr >= SMEM_BASE) && (bus.dma_addr <= LAST_SMEM_ADDR);
    assign pc_in_smem  = (bus.pc >= SMEM_BASE) && (bus.pc <= LAST_SMEM_ADDR);
    assign dma_viol    = bus.dma_req && dma_in_smem;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        mem_en_d   = 1'b0;
        mem_addr_d = 16'h0000;
        mem_sel_d  = 1'b0;
        cpu_gnt_d  = 1'b0;
        dma_gnt_d  = 1'b0;
        dma_deny_d = 1'b0;

        unique case (state_q)
            S_KILL: begin
                wait_d    = 4'd0;
                cpu_gnt_d = bus.cpu_req;
                if ((bus.pc == RESET_HANDLER) && !dma_viol)
                    state_d = S_RUN;
            end
            default: begin
                if (dma_viol) begin
                    // A refusal never occupies the port, so the CPU still proceeds.
                    dma_deny_d = 1'b1;
                    cpu_gnt_d  = bus.cpu_req;
                    wait_d     = 4'd0;
                    state_d    = S_KILL;
                end else if (bus.dma_req && pc_in_smem) begin
                    cpu_gnt_d = bus.cpu_req;
                end else if (bus.dma_req && (!bus.cpu_req || (wait_q == MAX_WAIT_C))) begin
                    dma_gnt_d = 1'b1;
                    wait_d    = 4'd0;
                end else if (bus.cpu_req) begin
                    cpu_gnt_d = 1'b1;
                    if (bus.dma_req)
                        wait_d = sat_inc_wait(wait_q);
                end
            end
        endcase

        if (cpu_gnt_d) begin
            mem_en_d   = 1'b1;
            mem_addr_d = bus.cpu_addr;
        end else if (dma_gnt_d) begin
            mem_en_d   = 1'b1;
            mem_addr_d = bus.dma_addr;
            mem_sel_d  = 1'b1;
        end
    end

    // Stage p1: registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_KILL;
            wait_q      <= 4'd0;
            kill_p1     <= 1'b1;
            mem_en_p1   <= 1'b0;
            mem_addr_p1 <= 16'h0000;
            mem_sel_p1  <= 1'b0;
            cpu_gnt_p1  <= 1'b0;
            dma_gnt_p1  <= 1'b0;
            dma_deny_p1 <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            kill_p1     <= (state_d == S_KILL);
            mem_en_p1   <= mem_en_d;
            mem_addr_p1 <= mem_addr_d;
            mem_sel_p1  <= mem_sel_d;
            cpu_gnt_p1  <= cpu_gnt_d;
            dma_gnt_p1  <= dma_gnt_d;
            dma_deny_p1 <= dma_deny_d;
        end
    end

    assign bus.mem_en   = mem_en_p1;
    assign bus.mem_addr = mem_addr_p1;
    assign bus.mem_sel  = mem_sel_p1;
    assign bus.cpu_gnt  = cpu_gnt_p1;
    assign bus.dma_gnt  = dma_gnt_p1;
    assign bus.dma_deny = dma_deny_p1;
    assign bus.kill     = kill_p1;

`ifdef DMA_VIOL_CNT_EN
    logic [7:0] viol_cnt_p1;

    always_ff @(posedge clk) begin
        if (reset)
            viol_cnt_p1 <= 8'h00;
        else if (dma_deny_d)
            viol_cnt_p1 <= sat_inc_viol(viol_cnt_p1);
    end

    assign bus.viol_cnt = viol_cnt_p1;
`endif

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: directed scenarios plus random traffic
// compared against a behavioural model of the sharing and isolation rules.
module tb_dma_bus_arbiter;

    localparam logic [15:0] SMEM_LO  = 16'hE000;
    localparam logic [15:0] SMEM_HI  = 16'hEFFE;
    localparam logic [15:0] RST_HNDL = 16'h0000;
    localparam int          MAXW     = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dma_bus_arbiter_if bus();

    dma_bus_arbiter #(
        .SMEM_BASE    (16'hE000),
        .SMEM_SIZE    (16'h1000),
        .RESET_HANDLER(16'h0000),
        .MAX_WAIT     (MAXW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: "is the CPU being killed", "how long has DMA waited".
    bit          m_kill = 1'b1;
    int          m_wait = 0;
    int          m_viol = 0;
    logic        e_mem_en, e_mem_sel, e_cpu_gnt, e_dma_gnt, e_dma_deny, e_kill;
    logic [15:0] e_mem_addr;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Predict what the arbiter shows after the coming edge, from the inputs it samples.
    task automatic model_edge();
        bit secure_dma;
        bit secure_pc;
        int winner;  // 0 nobody, 1 CPU, 2 DMA
        secure_dma = bus.dma_req && (bus.dma_addr >= SMEM_LO) && (bus.dma_addr <= SMEM_HI);
        secure_pc  = (bus.pc >= SMEM_LO) && (bus.pc <= SMEM_HI);
        winner     = 0;
        e_dma_deny = 1'b0;
        if (reset) begin
            m_kill = 1'b1;
            m_wait = 0;
            m_viol = 0;
        end else if (m_kill) begin
            winner = bus.cpu_req ? 1 : 0;
            m_wait = 0;
            if (bus.pc == RST_HNDL && !secure_dma)
                m_kill = 1'b0;
        end else if (secure_dma) begin
            e_dma_deny = 1'b1;
            winner     = bus.cpu_req ? 1 : 0;
            m_kill     = 1'b1;
            m_wait     = 0;
            m_viol     = (m_viol < 255) ? m_viol + 1 : 255;
        end else if (bus.dma_req && secure_pc) begin
            winner = bus.cpu_req ? 1 : 0;
        end else if (bus.dma_req && bus.cpu_req) begin
            if (m_wait == MAXW) begin
                winner = 2;
                m_wait = 0;
            end else begin
                winner = 1;
                m_wait = m_wait + 1;
            end
        end else if (bus.dma_req) begin
            winner = 2;
            m_wait = 0;
        end else if (bus.cpu_req) begin
            winner = 1;
        end
        e_cpu_gnt  = (winner == 1);
        e_dma_gnt  = (winner == 2);
        e_mem_en   = (winner != 0);
        e_mem_sel  = (winner == 2);
        e_mem_addr = (winner == 1) ? bus.cpu_addr : (winner == 2) ? bus.dma_addr : 16'h0000;
        e_kill     = m_kill;
    endtask

    task automatic check_all();
        chk1 ("mem_en",   bus.mem_en,   e_mem_en);
        chk16("mem_addr", bus.mem_addr, e_mem_addr);
        chk1 ("mem_sel",  bus.mem_sel,  e_mem_sel);
        chk1 ("cpu_gnt",  bus.cpu_gnt,  e_cpu_gnt);
        chk1 ("dma_gnt",  bus.dma_gnt,  e_dma_gnt);
        chk1 ("dma_deny", bus.dma_deny, e_dma_deny);
        chk1 ("kill",     bus.kill,     e_kill);
`ifdef DMA_VIOL_CNT_EN
        chk16("viol_cnt", {8'h00, bus.viol_cnt}, 16'(m_viol));
`endif
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        bus.pc       = 16'h1234;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = 16'h0000;
        bus.dma_req  = 1'b0;
        bus.dma_addr = 16'h0000;
        reset        = 1'b1;

        // Reset and exit through the reset handler
        cycle();
        cycle();
        chk1("rst_kill", bus.kill, 1'b1);
        chk1("rst_mem_en", bus.mem_en, 1'b0);
        reset  = 1'b0;
        bus.pc = 16'h0000;
        chk1("post_rst_kill", bus.kill, 1'b1);
        cycle();
        chk1("run_kill", bus.kill, 1'b0);

        // CPU priority with DMA starvation bound
        bus.pc       = 16'h4000;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 16'h1000;
        bus.dma_req  = 1'b1;
        bus.dma_addr = 16'h0200;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk1("starve_cpu_gnt", bus.cpu_gnt, 1'b1);
        end
        cycle();
        chk1 ("starve_dma_gnt", bus.dma_gnt, 1'b1);
        chk1 ("starve_sel", bus.mem_sel, 1'b1);
        chk16("starve_addr", bus.mem_addr, 16'h0200);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk1("restart_cpu_gnt", bus.cpu_gnt, 1'b1);
        end
        cycle();
        chk1("restart_dma_gnt", bus.dma_gnt, 1'b1);
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        cycle();

        // Violation on last SMEM word with concurrent CPU access
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 16'h1000;
        bus.dma_req  = 1'b1;
        bus.dma_addr = 16'hEFFE;
        cycle();
        chk1 ("viol_deny", bus.dma_deny, 1'b1);
        chk1 ("viol_cpu_gnt", bus.cpu_gnt, 1'b1);
        chk16("viol_addr", bus.mem_addr, 16'h1000);
        chk1 ("viol_kill", bus.kill, 1'b1);
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk1("kill_hold", bus.kill, 1'b1);
        end
        bus.pc = 16'h0000;
        cycle();
        chk1("kill_release", bus.kill, 1'b0);

        // Address boundaries around SMEM
        bus.pc       = 16'h4000;
        bus.dma_req  = 1'b1;
        bus.dma_addr = 16'hDFFE;
        cycle();
        chk1("bnd_dffe_gnt", bus.dma_gnt, 1'b1);
        bus.dma_addr = 16'hF000;
        cycle();
        chk1("bnd_f000_gnt", bus.dma_gnt, 1'b1);
        bus.dma_addr = 16'hE000;
        cycle();
        chk1("bnd_e000_deny", bus.dma_deny, 1'b1);
        chk1("bnd_e000_gnt", bus.dma_gnt, 1'b0);
        bus.dma_req = 1'b0;
        bus.pc      = 16'h0000;
        cycle();

        // DMA stalled while the CPU executes in SMEM
        bus.pc       = 16'hE010;
        bus.dma_req  = 1'b1;
        bus.dma_addr = 16'h0300;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk1("stall_gnt", bus.dma_gnt, 1'b0);
            chk1("stall_deny", bus.dma_deny, 1'b0);
        end
        bus.pc = 16'h4000;
        cycle();
        chk1 ("unstall_gnt", bus.dma_gnt, 1'b1);
        chk16("unstall_addr", bus.mem_addr, 16'h0300);
        bus.dma_req = 1'b0;
        cycle();

        // Exit attempt coinciding with a violation keeps KILL
        bus.dma_req  = 1'b1;
        bus.dma_addr = 16'hE100;
        cycle();
        chk1("sim_enter_kill", bus.kill, 1'b1);
        bus.pc = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk1("sim_kill", bus.kill, 1'b1);
            chk1("sim_deny", bus.dma_deny, 1'b0);
        end
        bus.dma_req = 1'b0;
        cycle();
        chk1("sim_exit", bus.kill, 1'b0);
`ifdef DMA_VIOL_CNT_EN
        chk16("viol_total", {8'h00, bus.viol_cnt}, 16'h0003);
`endif

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 3))
                0:       bus.pc = 16'h0000;
                1:       bus.pc = 16'h4000;
                2:       bus.pc = ($urandom_range(0, 1) == 0) ? 16'hE010 : 16'hEFFE;
                default: bus.pc = 16'($urandom);
            endcase
            bus.cpu_req  = 1'($urandom_range(0, 1));
            bus.cpu_addr = 16'($urandom);
            bus.dma_req  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       bus.dma_addr = 16'hDFFE;
                1:       bus.dma_addr = 16'hF000;
                2:       bus.dma_addr = ($urandom_range(0, 1) == 0) ? 16'hE000 : 16'hEFFE;
                3:       bus.dma_addr = 16'($urandom);
                default: bus.dma_addr = 16'($urandom_range(0, 16'hDFFF));
            endcase
            cycle();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Shares the single 16-bit memory port between the CPU fetch/data path and the DMA engine.
- Enforces secure-memory isolation on every DMA request: DMA into SMEM is refused and latched as a violation; DMA is stalled while the CPU executes inside SMEM.
- A violation drives a kill (CPU reset) request that holds until the CPU reaches the reset handler.
- Sits between the core's memory backbone and the memory, next to the existing pc-based monitors.

Parameters:
- SMEM_BASE, 16'hE000, first byte address of secure memory.
- SMEM_SIZE, 16'h1000, size of secure memory in bytes; last word LAST_SMEM_ADDR = SMEM_BASE + SMEM_SIZE - 2.
- RESET_HANDLER, 16'h0000, pc value at which a kill is released.
- MAX_WAIT, 4, number of lost arbitrations after which a pending legal DMA request wins; range 1..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pc  input  16  current CPU program counter.
- cpu_req  input  1  CPU memory request, level, held until cpu_gnt.
- cpu_addr  input  16  CPU request address.
- dma_req  input  1  DMA request, level, held until dma_gnt or dma_deny.
- dma_addr  input  16  DMA request address.
- mem_en  output  1  memory port enable for the granted access.
- mem_addr  output  16  address driven to memory (0 when mem_en=0).
- mem_sel  output  1  0 = CPU owns port, 1 = DMA owns port.
- cpu_gnt  output  1  one-cycle CPU grant.
- dma_gnt  output  1  one-cycle DMA grant.
- dma_deny  output  1  one-cycle refusal of a DMA request into SMEM.
- kill  output  1  CPU reset request.

Behaviour:
- All outputs are registered. Requests sampled at edge N produce grant/deny/mem_* outputs in cycle N+1 (latency 1).
- Reset values (while reset=1 at an edge): state=KILL, kill=1, wait_cnt=0, mem_en=0, mem_addr=0, mem_sel=0, cpu_gnt=0, dma_gnt=0, dma_deny=0. Reset takes precedence over all other events.
- A requester must hold its request until it sees its grant; a granted requester that still requests next cycle is arbitrated afresh.
- Address classification, inclusive on both ends:
  - dma_in_smem = SMEM_BASE <= dma_addr <= LAST_SMEM_ADDR.
  - pc_in_smem = SMEM_BASE <= pc <= LAST_SMEM_ADDR.
- State machine, two states:
  - RUN: kill=0.
    - dma_req & dma_in_smem → dma_deny=1 next cycle, state→KILL, kill=1 next cycle, no dma_gnt.
    - dma_req & !dma_in_smem & pc_in_smem → DMA stalled: no grant, no deny, wait_cnt unchanged.
    - Otherwise both requesters arbitrate (see arbitration).
  - KILL: kill=1.
    - DMA never granted or denied; dma_req ignored and wait_cnt held at 0.
    - CPU requests still granted.
    - → RUN when pc == RESET_HANDLER and NOT (dma_req & dma_in_smem) in the same cycle; otherwise remain KILL.
- Arbitration, RUN only, legal unstalled DMA:
  - CPU has priority.
  - When both request, DMA wins iff wait_cnt == MAX_WAIT.
  - wait_cnt increments, saturating at MAX_WAIT, each cycle DMA loses to CPU.
  - wait_cnt clears to 0 on dma_gnt.
- Grant cycle outputs: mem_en=1; mem_addr = winner's address; mem_sel = winner (1 for DMA).
- A deny does not use the port: a CPU request in the same cycle as a violation is still granted (cpu_gnt=1 alongside dma_deny=1).
- No requests, or only stalled/denied DMA: mem_en=0, mem_addr=0, mem_sel=0.
- Address range checks are unsigned 16-bit with no wrap; parameters must keep SMEM_BASE + SMEM_SIZE ≤ 17'h10000.

Optional Feature:
- DMA_VIOL_CNT_EN
- Defined: adds output viol_cnt [7:0], reset to 0, incremented on every dma_deny, saturating at 8'hFF, never cleared except by reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset exit: reset=1 for 2 cycles, then pc=16'h0000, no requests → kill=1 during reset and first cycle after; state RUN, kill=0 one cycle after pc=0 is sampled.
- CPU priority/starvation: RUN, pc=16'h4000, cpu_req and dma_req (dma_addr=16'h0200) held continuously, MAX_WAIT=4 → cpu_gnt 4 consecutive cycles, then dma_gnt=1 with mem_sel=1, mem_addr=16'h0200; wait_cnt back to 0.
- Violation: RUN, dma_req with dma_addr=16'hEFFE (last SMEM word) and cpu_req with cpu_addr=16'h1000 → next cycle dma_deny=1, cpu_gnt=1, mem_addr=16'h1000, kill=1; kill stays 1 until pc=16'h0000 is sampled.
- Boundaries: dma_addr=16'hDFFE → granted; 16'hE000 → denied; 16'hF000 → granted (RUN, pc outside SMEM).
- Atomic stall: pc=16'hE010, dma_req with dma_addr=16'h0300, no cpu_req → no dma_gnt, no dma_deny for all cycles pc is in SMEM; dma_gnt one cycle after pc moves to 16'h4000.
- Simultaneous exit and violation: KILL, pc=16'h0000 with dma_addr=16'hE100 → stays KILL, kill=1, dma_deny=0; with DMA_VIOL_CNT_EN, viol_cnt increments once per RUN-state violation only.
